// File: rtl/frac_stepper_pkg.sv
// Shared types and default widths for the fractional pixel stepper.
package frac_stepper_pkg;

  localparam int unsigned DEF_BITWIDTH  = 12;
  localparam int unsigned DEF_FRACWIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_MUL,
    S_CENTRE
  } state_t;

endpackage

// File: rtl/frac_stepper_if.sv
// Configuration, stepping controls and status of the fractional stepper.
interface frac_stepper_if #(
  parameter int unsigned BITWIDTH  = frac_stepper_pkg::DEF_BITWIDTH,
  parameter int unsigned FRACWIDTH = frac_stepper_pkg::DEF_FRACWIDTH
) ();

  logic [BITWIDTH-1:0]  num;
  logic [BITWIDTH-1:0]  den;
  logic [BITWIDTH-1:0]  limit;
  logic [BITWIDTH-1:0]  dst_size;
  logic                 auto_centre;
  logic [BITWIDTH-1:0]  centre_offset;
  logic                 int_mode;
  logic                 newfraction;
  logic                 step_reset;
  logic                 step_in;
  logic [FRACWIDTH-1:0] step_offset;
  logic                 ready;
  logic                 busy;
  logic                 div_err;
  logic [BITWIDTH-1:0]  limit_out;
  logic                 step_out;
  logic [BITWIDTH-1:0]  whole;
  logic [FRACWIDTH-1:0] fraction;
  logic                 blank;

  modport master (
    output num, den, limit, dst_size, auto_centre, centre_offset, int_mode,
           newfraction, step_reset, step_in, step_offset,
    input  ready, busy, div_err, limit_out, step_out, whole, fraction, blank
  );

  modport slave (
    input  num, den, limit, dst_size, auto_centre, centre_offset, int_mode,
           newfraction, step_reset, step_in, step_offset,
    output ready, busy, div_err, limit_out, step_out, whole, fraction, blank
  );

endinterface

// File: rtl/frac_divider.sv
// Restoring divider: {num, FRACWIDTH zeros} / den, one quotient bit per cycle.
module frac_divider import frac_stepper_pkg::*; #(
  parameter int unsigned BITWIDTH  = DEF_BITWIDTH,
  parameter int unsigned FRACWIDTH = DEF_FRACWIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  input  logic [BITWIDTH-1:0]           num,
  input  logic [BITWIDTH-1:0]           den,
  output logic                          ack_c,
  output logic [BITWIDTH+FRACWIDTH-1:0] quotient
);

  localparam int unsigned W  = BITWIDTH + FRACWIDTH;
  localparam int unsigned CW = $clog2(W + 1);

  logic [BITWIDTH-1:0] den_q;
  logic [BITWIDTH-1:0] rem;
  logic [CW-1:0]       count;
  logic                running;
  logic [BITWIDTH:0]   trial_c;
  logic                fits_c;

  // quotient doubles as the dividend shift register: MSB out, result bit in
  always_comb begin
    trial_c = {rem, quotient[W-1]};
    fits_c  = (trial_c >= {1'b0, den_q});
  end

  assign ack_c = running && (count == CW'(W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      den_q    <= '0;
      rem      <= '0;
      quotient <= '0;
      count    <= '0;
      running  <= 1'b0;
    end else if (req) begin
      den_q    <= den;
      rem      <= '0;
      quotient <= {num, FRACWIDTH'(0)};
      count    <= '0;
      running  <= 1'b1;
    end else if (running) begin
      rem      <= fits_c ? BITWIDTH'(trial_c - {1'b0, den_q}) : trial_c[BITWIDTH-1:0];
      quotient <= {quotient[W-2:0], fits_c};
      count    <= count + CW'(1);
      if (ack_c) running <= 1'b0;
    end
  end

endmodule

// File: rtl/frac_stepper.sv
// Fractional source/destination pixel stepper: computes num/den ratio, span
// size and centring offset, then walks source positions per output pixel.
module frac_stepper import frac_stepper_pkg::*; #(
  parameter int unsigned BITWIDTH  = DEF_BITWIDTH,
  parameter int unsigned FRACWIDTH = DEF_FRACWIDTH
) (
  input logic           clk,
  input logic           reset,
  frac_stepper_if.slave bus
);

  localparam int unsigned W  = BITWIDTH + FRACWIDTH;
  localparam int unsigned PW = W + BITWIDTH;

  state_t               state, state_next;
  logic                 div_ack_c;
  logic [W-1:0]         quotient;
  logic [W-1:0]         step, step_c, spos;
  logic [PW-1:0]        prod_c, prod_shift_c;
  logic [BITWIDTH-1:0]  limit_c, diff_c, centre_c, whole_next_c;
  logic [BITWIDTH-1:0]  offset_active, offset, dpos;
  logic                 int_mode_q, tail, advance_c;
  logic                 ready, busy, div_err, step_out, blank;
  logic [BITWIDTH-1:0]  limit_out, whole;
  logic [FRACWIDTH-1:0] fraction;

  frac_divider #(.BITWIDTH(BITWIDTH), .FRACWIDTH(FRACWIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.newfraction),
    .num      (bus.num),
    .den      (bus.den),
    .ack_c    (div_ack_c),
    .quotient (quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.newfraction) begin
      state_next = S_DIV;
    end else begin
      case (state)
        S_DIV:    if (div_ack_c) state_next = S_MUL;
        S_MUL:    state_next = S_CENTRE;
        S_CENTRE: state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Ratio post-processing, span size, centring and step decision
  always_comb begin
    if (div_err) begin
      step_c = '1;
    end else if (int_mode_q) begin
      step_c = (quotient[W-1:FRACWIDTH] == '0) ? (W'(1) << FRACWIDTH)
                                                : {quotient[W-1:FRACWIDTH], FRACWIDTH'(0)};
    end else begin
      step_c = quotient;
    end
    prod_c       = PW'(step_c) * PW'(bus.limit);
    prod_shift_c = prod_c >> FRACWIDTH;
    limit_c      = (prod_shift_c[PW-1:BITWIDTH] != '0) ? '1 : prod_shift_c[BITWIDTH-1:0];
    diff_c       = bus.dst_size - limit_out;
    if (bus.auto_centre) centre_c = (bus.dst_size > limit_out) ? (diff_c >> 1) : '0;
    else                 centre_c = bus.centre_offset;
    advance_c    = (dpos > spos[W-1:FRACWIDTH]);
    whole_next_c = (advance_c && !tail) ? whole + BITWIDTH'(1) : whole;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready         <= 1'b0;
      busy          <= 1'b0;
      div_err       <= 1'b0;
      step_out      <= 1'b0;
      whole         <= '0;
      fraction      <= '0;
      limit_out     <= '0;
      step          <= '0;
      spos          <= '0;
      dpos          <= '0;
      offset        <= '0;
      offset_active <= '0;
      tail          <= 1'b0;
      blank         <= 1'b1;
      int_mode_q    <= 1'b0;
    end else begin
      step_out <= 1'b0;
      busy     <= (state_next != S_IDLE);

      if (bus.newfraction || bus.step_reset) begin
        spos     <= {BITWIDTH'(0), bus.step_offset};
        dpos     <= '0;
        whole    <= '0;
        fraction <= '0;
        offset   <= offset_active;
        tail     <= 1'b0;
        blank    <= bus.newfraction || !ready || (offset_active != '0);
      end else if (bus.step_in && ready) begin
        if (offset != '0) begin
          offset <= offset - BITWIDTH'(1);
          blank  <= 1'b1;
        end else begin
          // blank and step_out reflect tail as it stood before this pixel
          dpos  <= dpos + BITWIDTH'(1);
          blank <= tail;
          whole <= whole_next_c;
          tail  <= tail || (whole_next_c == bus.limit);
          if (advance_c) begin
            spos     <= spos + step;
            fraction <= spos[FRACWIDTH-1:0];
            step_out <= !tail;
          end else begin
            fraction <= '0;
          end
        end
      end

      if (bus.newfraction) begin
        ready      <= 1'b0;
        div_err    <= (bus.den == '0);
        int_mode_q <= bus.int_mode;
      end else begin
        case (state)
          S_MUL: begin
            step      <= step_c;
            limit_out <= limit_c;
          end
          S_CENTRE: begin
            offset_active <= centre_c;
            offset        <= centre_c;
            blank         <= (centre_c != '0);
            ready         <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.div_err   = div_err;
  assign bus.limit_out = limit_out;
  assign bus.step_out  = step_out;
  assign bus.whole     = whole;
  assign bus.fraction  = fraction;
  assign bus.blank     = blank;

endmodule

// File: tb/tb_frac_stepper.sv
// Directed, table-driven bench for frac_stepper with hand-computed expectations.
module tb_frac_stepper;
  import frac_stepper_pkg::*;

  localparam int unsigned BW = DEF_BITWIDTH;
  localparam int unsigned FW = DEF_FRACWIDTH;
  localparam int unsigned W  = BW + FW;

  typedef struct {
    logic [BW-1:0] num;
    logic [BW-1:0] den;
    logic [BW-1:0] limit;
    logic [BW-1:0] dst_size;
    logic [BW-1:0] centre_offset;
    logic          auto_centre;
    logic          int_mode;
    logic [W-1:0]  exp_step;
    logic [BW-1:0] exp_limit;
    logic          exp_err;
    int            exp_offset;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frac_stepper_if #(.BITWIDTH(BW), .FRACWIDTH(FW)) bus ();
  frac_stepper #(.BITWIDTH(BW), .FRACWIDTH(FW)) dut (.clk(clk), .reset(reset), .bus(bus));

  vec_t vecs [9];
  int   n_checks;
  int   n_fail;
  int   lat;
  int   nb;
  int   ready_seen;
  int   blank_low;

  int so_a [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
  int bl_a [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  int wh_a [10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4};
  int so_b [9]  = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
  int bl_b [9]  = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
  int fr_b [9]  = '{0, 0, 0, 0, 'h8000, 0, 0, 'h8000, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_inputs(input vec_t v);
    bus.num           = v.num;
    bus.den           = v.den;
    bus.limit         = v.limit;
    bus.dst_size      = v.dst_size;
    bus.centre_offset = v.centre_offset;
    bus.auto_centre   = v.auto_centre;
    bus.int_mode      = v.int_mode;
  endtask

  task automatic pulse_nf();
    bus.newfraction = 1'b1;
    cycle();
    bus.newfraction = 1'b0;
  endtask

  // Cycles until ready rises; 0 means it never did within the bound
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 100; i++) begin
      cycle();
      if (bus.ready) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic load_ratio(input vec_t v, output int cycles);
    apply_inputs(v);
    pulse_nf();
    wait_ready(cycles);
  endtask

  task automatic step_once(input logic with_reset);
    bus.step_in    = 1'b1;
    bus.step_reset = with_reset;
    cycle();
    bus.step_in    = 1'b0;
    bus.step_reset = 1'b0;
  endtask

  task automatic span_start();
    bus.step_reset = 1'b1;
    cycle();
    bus.step_reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //          num      den     limit      dst      cofs    auto  int   step          limit    err   ofs
    vecs[0] = '{12'd2,    12'd1, 12'd4,    12'd0,  12'd0,  1'b0, 1'b0, 28'h0020000, 12'd8,    1'b0, 0};
    vecs[1] = '{12'd3,    12'd2, 12'd4,    12'd10, 12'd0,  1'b1, 1'b0, 28'h0018000, 12'd6,    1'b0, 2};
    vecs[2] = '{12'd7,    12'd0, 12'd4,    12'd0,  12'd3,  1'b0, 1'b0, 28'hFFFFFFF, 12'hFFF,  1'b1, 3};
    vecs[3] = '{12'd4095, 12'd1, 12'd4095, 12'd0,  12'd0,  1'b0, 1'b0, 28'hFFF0000, 12'hFFF,  1'b0, 0};
    vecs[4] = '{12'd5,    12'd2, 12'd4,    12'd0,  12'd0,  1'b0, 1'b1, 28'h0020000, 12'd8,    1'b0, 0};
    vecs[5] = '{12'd1,    12'd3, 12'd7,    12'd7,  12'd0,  1'b1, 1'b1, 28'h0010000, 12'd7,    1'b0, 0};
    vecs[6] = '{12'd1,    12'd3, 12'd9,    12'd20, 12'd0,  1'b1, 1'b0, 28'h0005555, 12'd2,    1'b0, 9};
    vecs[7] = '{12'd3,    12'd4, 12'd100,  12'd80, 12'd0,  1'b1, 1'b0, 28'h000C000, 12'd75,   1'b0, 2};
    vecs[8] = '{12'd10,   12'd3, 12'd5,    12'd0,  12'd1,  1'b0, 1'b1, 28'h0030000, 12'd15,   1'b0, 1};

    reset           = 1'b1;
    apply_inputs(vecs[0]);
    bus.newfraction = 1'b0;
    bus.step_reset  = 1'b0;
    bus.step_in     = 1'b0;
    bus.step_offset = '0;
    repeat (3) @(negedge clk);

    check("rst ready", 32'(bus.ready), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst blank", 32'(bus.blank), 1);
    check("rst step_out", 32'(bus.step_out), 0);
    check("rst limit_out", 32'(bus.limit_out), 0);
    check("rst div_err", 32'(bus.div_err), 0);
    reset = 1'b0;
    cycle();

    // Ratio table: latency, step, span, error flag, centring offset
    for (int i = 0; i < 9; i++) begin
      load_ratio(vecs[i], lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(W + 2));
      check($sformatf("v%0d step", i), 32'(dut.step), 32'(vecs[i].exp_step));
      check($sformatf("v%0d limit_out", i), 32'(bus.limit_out), 32'(vecs[i].exp_limit));
      check($sformatf("v%0d div_err", i), 32'(bus.div_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d busy", i), 32'(bus.busy), 0);
      span_start();
      nb = 0;
      for (int k = 0; k < 40; k++) begin
        step_once(1'b0);
        if (!bus.blank) break;
        nb++;
      end
      check($sformatf("v%0d offset", i), 32'(nb), 32'(vecs[i].exp_offset));
    end

    // Ratio 2.0 over a 4-pixel source: advance every other pixel, then tail
    load_ratio(vecs[0], lat);
    span_start();
    for (int k = 0; k < 10; k++) begin
      step_once(1'b0);
      check($sformatf("A step_out #%0d", k + 1), 32'(bus.step_out), 32'(so_a[k]));
      check($sformatf("A blank #%0d", k + 1), 32'(bus.blank), 32'(bl_a[k]));
      check($sformatf("A whole #%0d", k + 1), 32'(bus.whole), 32'(wh_a[k]));
    end

    // Ratio 1.5 auto-centred in 10: two blanked pixels, then half-pixel phases
    load_ratio(vecs[1], lat);
    span_start();
    for (int k = 0; k < 9; k++) begin
      step_once(1'b0);
      check($sformatf("B step_out #%0d", k + 1), 32'(bus.step_out), 32'(so_b[k]));
      check($sformatf("B blank #%0d", k + 1), 32'(bus.blank), 32'(bl_b[k]));
      check($sformatf("B fraction #%0d", k + 1), 32'(bus.fraction), 32'(fr_b[k]));
    end

    // step_reset beats a simultaneous step_in
    load_ratio(vecs[0], lat);
    span_start();
    repeat (4) step_once(1'b0);
    check("C whole before", 32'(bus.whole), 2);
    step_once(1'b1);
    check("C whole after reset", 32'(bus.whole), 0);
    check("C step_out after reset", 32'(bus.step_out), 0);
    step_once(1'b0);
    step_once(1'b0);
    check("C step_out restart", 32'(bus.step_out), 1);
    check("C whole restart", 32'(bus.whole), 1);

    // newfraction beats step_in, resets the span, and step_in is ignored until ready
    bus.step_in = 1'b1;
    pulse_nf();
    check("D ready", 32'(bus.ready), 0);
    check("D whole", 32'(bus.whole), 0);
    check("D blank", 32'(bus.blank), 1);
    check("D busy", 32'(bus.busy), 1);
    repeat (3) cycle();
    bus.step_in = 1'b0;
    check("D whole ignored", 32'(bus.whole), 0);
    check("D blank not ready", 32'(bus.blank), 1);
    wait_ready(lat);
    check("D latency", 32'(lat), 32'(W + 2 - 3));

    // newfraction mid-division restarts the computation
    apply_inputs(vecs[1]);
    pulse_nf();
    repeat (10) cycle();
    check("E busy", 32'(bus.busy), 1);
    load_ratio(vecs[0], lat);
    check("E latency", 32'(lat), 32'(W + 2));
    check("E step", 32'(dut.step), 32'h0020000);
    check("E limit_out", 32'(bus.limit_out), 8);

    // Asynchronous reset in the middle of a division
    apply_inputs(vecs[2]);
    pulse_nf();
    check("F div_err set", 32'(bus.div_err), 1);
    repeat (5) cycle();
    #2 reset = 1'b1;
    #1;
    check("F ready", 32'(bus.ready), 0);
    check("F busy", 32'(bus.busy), 0);
    check("F div_err", 32'(bus.div_err), 0);
    check("F limit_out", 32'(bus.limit_out), 0);
    check("F blank", 32'(bus.blank), 1);
    @(negedge clk);
    reset      = 1'b0;
    ready_seen = 0;
    blank_low  = 0;
    for (int k = 0; k < 50; k++) begin
      bus.step_in = k[0];
      cycle();
      if (bus.ready) ready_seen++;
      if (!bus.blank) blank_low++;
    end
    bus.step_in = 1'b0;
    check("F ready stays low", 32'(ready_seen), 0);
    check("F blank stays high", 32'(blank_low), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
